dac_soft_gate: RTL and testbench



---
 rtl/dac_soft_gate_pkg.sv | 16 +
 rtl/dac_soft_gate_channel.sv | 159 +++++++++++++++
 rtl/dac_soft_gate.sv | 41 ++++
 tb/tb_dac_soft_gate.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/dac_soft_gate_pkg.sv
// Shared types and default dimensions for the DAC soft gate.
package dac_soft_gate_pkg;

    localparam int TX_CHANNELS         = 2;
    localparam int TX_PARALLEL_SAMPLES = 2;
    localparam int TX_SAMPLE_WIDTH     = 16;
    localparam int GATE_GAIN_BITS      = 16;

    typedef enum logic [1:0] {
        OFF       = 2'd0,
        RAMP_UP   = 2'd1,
        ON        = 2'd2,
        RAMP_DOWN = 2'd3
    } gate_state_t;

endpackage

// File: rtl/dac_soft_gate_channel.sv
// One DAC channel: envelope state machine, gain register and two-stage
// gain multiplier shared by all parallel samples of the channel.
module dac_soft_gate_channel
    import dac_soft_gate_pkg::*;
#(
    parameter int GAIN_BITS        = GATE_GAIN_BITS,
    parameter int PARALLEL_SAMPLES = TX_PARALLEL_SAMPLES,
    parameter int SAMPLE_WIDTH     = TX_SAMPLE_WIDTH
) (
    input  logic                                     clk,
    input  logic                                     reset_n,
    input  logic [PARALLEL_SAMPLES*SAMPLE_WIDTH-1:0] samples,
    input  logic                                     samples_valid,
    input  logic                                     enable,
    input  logic [GAIN_BITS-1:0]                     ramp_step,
    output logic [PARALLEL_SAMPLES*SAMPLE_WIDTH-1:0] gated,
    output logic                                     gated_valid,
    output logic                                     active,
    output logic                                     settled
);

    localparam int PROD_W = SAMPLE_WIDTH + GAIN_BITS + 2;
    localparam logic [GAIN_BITS:0] UNITY = {1'b1, {GAIN_BITS{1'b0}}};

    gate_state_t                   state, state_next;
    logic        [GAIN_BITS:0]     gain, gain_next;
    logic        [GAIN_BITS-1:0]   step, step_next;
    logic        [GAIN_BITS+1:0]   sum;
    logic                          go_up, go_down;

    logic [PARALLEL_SAMPLES*SAMPLE_WIDTH-1:0] samples_p1;
    logic                                     vld_p1;
    logic [PARALLEL_SAMPLES*SAMPLE_WIDTH-1:0] scaled;
    logic [PARALLEL_SAMPLES*SAMPLE_WIDTH-1:0] gated_p2;
    logic                                     vld_p2;

    // Taking bits above the fraction is an arithmetic shift that floors toward -inf.
    function automatic logic signed [SAMPLE_WIDTH-1:0] scale(
        input logic signed [SAMPLE_WIDTH-1:0] s,
        input logic        [GAIN_BITS:0]      g
    );
        logic signed [PROD_W-1:0] prod;
        prod = PROD_W'(s) * PROD_W'($signed({1'b0, g}));
        return prod[GAIN_BITS +: SAMPLE_WIDTH];
    endfunction

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= OFF;
            gain  <= '0;
            step  <= '0;
        end else begin
            state <= state_next;
            gain  <= gain_next;
            step  <= step_next;
        end
    end

    // The first increment/decrement is applied in the cycle the ramp starts or reverses.
    always_comb begin
        state_next = state;
        gain_next  = gain;
        step_next  = step;
        go_up      = 1'b0;
        go_down    = 1'b0;
        case (state)
            OFF: begin
                if (enable) begin
                    step_next = ramp_step;
                    go_up     = 1'b1;
                end
            end
            RAMP_UP: begin
                if (!enable) begin
                    step_next = ramp_step;
                    go_down   = 1'b1;
                end else begin
                    go_up = 1'b1;
                end
            end
            ON: begin
                if (!enable) begin
                    step_next = ramp_step;
                    go_down   = 1'b1;
                end
            end
            RAMP_DOWN: begin
                if (enable) begin
                    step_next = ramp_step;
                    go_up     = 1'b1;
                end else begin
                    go_down = 1'b1;
                end
            end
            default: begin
                state_next = OFF;
                gain_next  = '0;
            end
        endcase

        sum = {1'b0, gain} + {2'b00, step_next};
        if (go_up) begin
            if (step_next == '0 || sum >= {1'b0, UNITY}) begin
                gain_next  = UNITY;
                state_next = ON;
            end else begin
                gain_next  = sum[GAIN_BITS:0];
                state_next = RAMP_UP;
            end
        end else if (go_down) begin
            if (step_next == '0 || gain <= {1'b0, step_next}) begin
                gain_next  = '0;
                state_next = OFF;
            end else begin
                gain_next  = gain - {1'b0, step_next};
                state_next = RAMP_DOWN;
            end
        end
    end

    always_comb begin
        active  = (state != OFF);
        settled = (state == OFF) || (state == ON);
    end

    // Stage 1: sample captured alongside the gain register updated on the same edge.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            samples_p1 <= '0;
            vld_p1     <= 1'b0;
        end else begin
            samples_p1 <= samples;
            vld_p1     <= samples_valid;
        end
    end

    always_comb begin
        scaled = '0;
        for (int i = 0; i < PARALLEL_SAMPLES; i++) begin
            scaled[i*SAMPLE_WIDTH +: SAMPLE_WIDTH] =
                scale($signed(samples_p1[i*SAMPLE_WIDTH +: SAMPLE_WIDTH]), gain);
        end
    end

    // Stage 2: registered product.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            gated_p2 <= '0;
            vld_p2   <= 1'b0;
        end else begin
            gated_p2 <= scaled;
            vld_p2   <= vld_p1;
        end
    end

    assign gated       = gated_p2;
    assign gated_valid = vld_p2;

endmodule

// File: rtl/dac_soft_gate.sv
// Per-channel linear amplitude gate between the transmit chain and the RFDAC.
module dac_soft_gate
    import dac_soft_gate_pkg::*;
#(
    parameter int GAIN_BITS        = GATE_GAIN_BITS,
    parameter int CHANNELS         = TX_CHANNELS,
    parameter int PARALLEL_SAMPLES = TX_PARALLEL_SAMPLES,
    parameter int SAMPLE_WIDTH     = TX_SAMPLE_WIDTH
) (
    input  logic                                                   dac_clk,
    input  logic                                                   dac_reset_n,
    input  logic [CHANNELS-1:0][PARALLEL_SAMPLES*SAMPLE_WIDTH-1:0] data_in,
    input  logic [CHANNELS-1:0]                                    data_in_valid,
    output logic [CHANNELS-1:0][PARALLEL_SAMPLES*SAMPLE_WIDTH-1:0] data_out,
    output logic [CHANNELS-1:0]                                    data_out_valid,
    input  logic [CHANNELS-1:0]                                    enable,
    input  logic [CHANNELS*GAIN_BITS-1:0]                          ramp_step,
    output logic [CHANNELS-1:0]                                    gate_active,
    output logic [CHANNELS-1:0]                                    gate_settled
);

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        dac_soft_gate_channel #(
            .GAIN_BITS        (GAIN_BITS),
            .PARALLEL_SAMPLES (PARALLEL_SAMPLES),
            .SAMPLE_WIDTH     (SAMPLE_WIDTH)
        ) u_ch (
            .clk           (dac_clk),
            .reset_n       (dac_reset_n),
            .samples       (data_in[c]),
            .samples_valid (data_in_valid[c]),
            .enable        (enable[c]),
            .ramp_step     (ramp_step[c*GAIN_BITS +: GAIN_BITS]),
            .gated         (data_out[c]),
            .gated_valid   (data_out_valid[c]),
            .active        (gate_active[c]),
            .settled       (gate_settled[c])
        );
    end

endmodule

// File: tb/tb_dac_soft_gate.sv
// Directed bench for dac_soft_gate: ramps, reversal, zero-step jumps, floor, reset.
module tb_dac_soft_gate;

    localparam int CH = 2;
    localparam int PS = 2;
    localparam int SW = 16;
    localparam int GB = 16;

    logic                        dac_clk = 1'b0;
    logic                        dac_reset_n;
    logic [CH-1:0][PS*SW-1:0]    data_in;
    logic [CH-1:0]               data_in_valid;
    logic [CH-1:0][PS*SW-1:0]    data_out;
    logic [CH-1:0]               data_out_valid;
    logic [CH-1:0]               enable;
    logic [CH*GB-1:0]            ramp_step;
    logic [CH-1:0]               gate_active;
    logic [CH-1:0]               gate_settled;

    int n_vec = 0;
    int n_err = 0;

    dac_soft_gate #(
        .GAIN_BITS        (GB),
        .CHANNELS         (CH),
        .PARALLEL_SAMPLES (PS),
        .SAMPLE_WIDTH     (SW)
    ) dut (
        .dac_clk        (dac_clk),
        .dac_reset_n    (dac_reset_n),
        .data_in        (data_in),
        .data_in_valid  (data_in_valid),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .enable         (enable),
        .ramp_step      (ramp_step),
        .gate_active    (gate_active),
        .gate_settled   (gate_settled)
    );

    always #5 dac_clk = ~dac_clk;

    task automatic tick();
        @(posedge dac_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic signed [31:0] lane(input int ch, input int l);
        logic signed [SW-1:0] v;
        v = data_out[ch][l*SW +: SW];
        return 32'(v);
    endfunction

    task automatic set_lanes(input int ch, input int a, input int b);
        data_in[ch][SW-1:0]    = SW'(a);
        data_in[ch][2*SW-1:SW] = SW'(b);
    endtask

    task automatic set_step(input int ch, input int v);
        ramp_step[ch*GB +: GB] = GB'(v);
    endtask

    initial begin
        int up_exp[5];
        int up_set[5];
        int dn_exp[5];
        int dn_act[5];
        up_exp = '{0, 250, 500, 750, 1000};
        up_set = '{0, 0, 0, 1, 1};
        dn_exp = '{1000, 750, 500, 250, 0};
        dn_act = '{1, 1, 1, 0, 0};

        dac_reset_n   = 1'b0;
        enable        = '0;
        ramp_step     = '0;
        data_in       = '0;
        data_in_valid = '0;
        tick();
        tick();
        chk("rst_data", lane(0, 0), 0);
        chk("rst_valid", 32'(data_out_valid), 0);
        chk("rst_active", 32'(gate_active), 0);
        chk("rst_settled", 32'(gate_settled), 3);

        // Gate closed: zeros out, valid delayed by two cycles.
        dac_reset_n = 1'b1;
        set_lanes(0, 1000, 1000);
        set_lanes(1, 1000, 1000);
        data_in_valid = 2'b11;
        tick();
        chk("lat_valid_e1", 32'(data_out_valid), 0);
        tick();
        chk("off_valid", 32'(data_out_valid), 3);
        chk("off_data0", lane(0, 0), 0);
        chk("off_data1", lane(1, 1), 0);
        data_in_valid = 2'b10;
        tick();
        chk("valid_hold", 32'(data_out_valid), 3);
        data_in_valid = 2'b11;
        tick();
        chk("valid_follow", 32'(data_out_valid), 2);
        tick();
        chk("valid_back", 32'(data_out_valid), 3);
        chk("off_settled", 32'(gate_settled), 3);

        // ch0 ramp up, quarter-scale steps.
        set_step(0, 16384);
        set_step(1, 16384);
        enable = 2'b01;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk($sformatf("up_out%0d", k), lane(0, 0), up_exp[k]);
            chk($sformatf("up_settled%0d", k), 32'(gate_settled[0]), up_set[k]);
        end
        chk("up_active", 32'(gate_active[0]), 1);
        chk("up_lane1", lane(0, 1), 1000);
        chk("up_ch1_off", lane(1, 0), 0);

        set_lanes(0, -32768, 32767);
        tick();
        tick();
        chk("exact_min", lane(0, 0), -32768);
        chk("exact_max", lane(0, 1), 32767);

        // ch1 immediate on with zero step, then ramp down.
        set_step(1, 0);
        enable = 2'b11;
        tick();
        chk("jump_on_active", 32'(gate_active[1]), 1);
        chk("jump_on_settled", 32'(gate_settled[1]), 1);
        tick();
        chk("jump_on_out", lane(1, 0), 1000);
        set_step(1, 16384);
        enable = 2'b01;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk($sformatf("dn_out%0d", k), lane(1, 0), dn_exp[k]);
            chk($sformatf("dn_active%0d", k), 32'(gate_active[1]), dn_act[k]);
        end

        // Reversal on ch1: up three steps of 8192, then back down.
        set_step(1, 8192);
        enable = 2'b11;
        tick();
        tick();
        chk("rev_out1", lane(1, 0), 125);
        tick();
        chk("rev_out2", lane(1, 0), 250);
        enable = 2'b01;
        tick();
        chk("rev_out3", lane(1, 0), 375);
        tick();
        chk("rev_out4", lane(1, 1), 250);
        tick();
        chk("rev_out5", lane(1, 0), 125);
        chk("rev_settled", 32'(gate_settled[1]), 1);
        chk("rev_active", 32'(gate_active[1]), 0);
        tick();
        chk("rev_out6", lane(1, 0), 0);

        // ch0 zero-step jumps off and on.
        set_step(0, 0);
        enable = 2'b00;
        set_lanes(0, 1000, 1000);
        tick();
        chk("jump_off_active", 32'(gate_active[0]), 0);
        chk("jump_off_settled", 32'(gate_settled[0]), 1);
        tick();
        chk("jump_off_out", lane(0, 0), 0);
        enable = 2'b01;
        tick();
        chk("jump_on0_active", 32'(gate_active[0]), 1);
        chk("jump_on0_settled", 32'(gate_settled[0]), 1);
        tick();
        chk("jump_on0_out", lane(0, 0), 1000);

        // Half gain floor behaviour.
        set_step(0, 32768);
        enable = 2'b00;
        set_lanes(0, -1, 1);
        tick();
        chk("half_settled", 32'(gate_settled[0]), 0);
        tick();
        chk("floor_neg", lane(0, 0), -1);
        chk("floor_pos", lane(0, 1), 0);

        // Reset in the middle of a ramp on both channels.
        set_step(0, 8192);
        set_step(1, 8192);
        set_lanes(0, 1000, 1000);
        set_lanes(1, 1000, 1000);
        enable = 2'b11;
        tick();
        tick();
        chk("pre_rst_ch0", lane(0, 0), 125);
        chk("pre_rst_ch1", lane(1, 0), 125);
        dac_reset_n = 1'b0;
        tick();
        chk("mid_rst_ch0", lane(0, 0), 0);
        chk("mid_rst_ch1", lane(1, 1), 0);
        chk("mid_rst_valid", 32'(data_out_valid), 0);
        chk("mid_rst_active", 32'(gate_active), 0);
        chk("mid_rst_settled", 32'(gate_settled), 3);
        dac_reset_n = 1'b1;
        tick();
        chk("restart_active", 32'(gate_active), 3);
        chk("restart_settled", 32'(gate_settled), 0);
        tick();
        chk("restart_ch0", lane(0, 0), 125);
        chk("restart_ch1", lane(1, 1), 125);
        chk("restart_valid", 32'(data_out_valid), 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
